// File: rtl/fl.sv
// +----------------------------------------------------------------------------+
// | fl : circular physical-register free list for a 2-wide R10K rename stage    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module fl #(
  parameter int FL_SIZE = 96,
  parameter int PR_BASE = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] rob_dispatch_num,
  input  logic       rob_ar_a_valid,
  input  logic       rob_ar_b_valid,
  input  logic [1:0] rob_retire_num,
  input  logic [6:0] rob_told0,
  input  logic [6:0] rob_told1,
  input  logic       rob_told0_valid,
  input  logic       rob_told1_valid,
  input  logic       rob_mispredict,
  output logic [6:0] fl_pr0,
  output logic [6:0] fl_pr1,
  output logic [6:0] fl_free_count,
  output logic [1:0] fl_avail_num
);

  localparam int                PTR_W     = $clog2(FL_SIZE);
  localparam logic [PTR_W:0]    c_fl_size = (PTR_W + 1)'(FL_SIZE);
  localparam logic [6:0]        c_count_f = 7'(FL_SIZE);

  logic [6:0]       entry_q [FL_SIZE];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [6:0]       count_q, count_d;

  logic             w_alloc_a, w_alloc_b;
  logic [1:0]       w_pop, w_pop_eff;
  logic             w_push0, w_push1;
  logic [1:0]       w_push;
  logic [PTR_W-1:0] w_head_p1, w_tail_p1, w_wr1_idx;

  // FL_SIZE need not be a power of two, so every pointer step wraps explicitly.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + {{(PTR_W - 1){1'b0}}, n};
    if (s >= c_fl_size) s = s - c_fl_size;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    w_alloc_a = (rob_dispatch_num >= 2'd1) && rob_ar_a_valid;
    w_alloc_b = (rob_dispatch_num == 2'd2) && rob_ar_b_valid;
    w_pop     = {1'b0, w_alloc_a} + {1'b0, w_alloc_b};
    w_push0   = (rob_retire_num >= 2'd1) && rob_told0_valid;
    w_push1   = (rob_retire_num == 2'd2) && rob_told1_valid;
    w_push    = {1'b0, w_push0} + {1'b0, w_push1};

    w_head_p1 = wrap_add(head_q, 2'd1);
    w_tail_p1 = wrap_add(tail_q, 2'd1);
    // Valid tolds are packed: slot 1 lands at tail only when slot 0 is empty.
    w_wr1_idx = w_push0 ? w_tail_p1 : tail_q;

    w_pop_eff = 2'd0;
    if (!rob_mispredict && ({5'b0, w_pop} <= count_q)) w_pop_eff = w_pop;

    tail_d  = wrap_add(tail_q, w_push);
    head_d  = wrap_add(head_q, w_pop_eff);
    count_d = count_q + {5'b0, w_push} - {5'b0, w_pop_eff};
    if (rob_mispredict) begin
      head_d  = tail_d;
      count_d = c_count_f;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < FL_SIZE; i++) entry_q[i] <= 7'(PR_BASE + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= c_count_f;
    end else begin
      if (w_push0) entry_q[tail_q]    <= rob_told0;
      if (w_push1) entry_q[w_wr1_idx] <= rob_told1;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign fl_pr0        = entry_q[head_q];
  assign fl_pr1        = w_alloc_a ? entry_q[w_head_p1] : entry_q[head_q];
  assign fl_free_count = count_q;
  assign fl_avail_num  = (count_q >= 7'd2) ? 2'd2 : count_q[1:0];

endmodule

`default_nettype wire
